// File: rtl/uart_word_streamer_if.sv
// Control, memory-read and serial-line signals of the UART word streamer.
// The slave modport is the streamer's view; master is the driver's view.
interface uart_word_streamer_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_address;
    logic [15:0]       rd_data;
    logic              UART_TXD;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, base_addr, num_words, rd_data,
        input  rd_en, rd_address, UART_TXD, busy, done
    );

    modport slave (
        input  start, abort, base_addr, num_words, rd_data,
        output rd_en, rd_address, UART_TXD, busy, done
    );
endinterface

// File: rtl/uart_word_streamer.sv
// Streams 16-bit words from a synchronous memory out of an 8N1 UART line,
// low byte first, with its own bit serializer and sticky abort.
module uart_word_streamer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 14
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    uart_word_streamer_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND_LO,
        SEND_HI,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [15:0]       word_q, word_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic              abort_q, abort_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        cur_byte;

    // Line level for frame position i: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] i);
        logic [3:0] j;
        j = i - 4'd1;
        if (i == 4'd0)
            return 1'b0;
        else if (i >= 4'd9)
            return 1'b1;
        else
            return b[j[2:0]];
    endfunction

    assign cur_byte = (state_q == SEND_HI) ? word_q[15:8] : word_q[7:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        abort_d = (state_q == IDLE) ? 1'b0 : (abort_q | bus.abort);

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (bus.start) begin
                    addr_d  = bus.base_addr;
                    rem_d   = bus.num_words;
                    abort_d = bus.abort;
                    state_d = (bus.num_words != '0) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                word_d  = bus.rd_data;
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - ADDR_W'(1);
                cnt_d   = '0;
                bit_d   = '0;
                txd_d   = 1'b0;
                state_d = SEND_LO;
            end
            SEND_LO, SEND_HI: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        bit_d = bit_q + 4'd1;
                        txd_d = frame_bit(cur_byte, bit_q + 4'd1);
                    end else begin
                        bit_d = '0;
                        // High byte always follows so a word is never split.
                        if (state_q == SEND_LO) begin
                            txd_d   = 1'b0;
                            state_d = SEND_HI;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = (rem_q == '0 || abort_d) ? FINISH : FETCH;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
        rd_en_d   = (state_d == FETCH);
        rd_addr_d = rd_en_d ? addr_d : rd_addr_q;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            abort_q   <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            abort_q   <= abort_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign bus.UART_TXD   = txd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_address = rd_addr_q;
endmodule

// File: tb/tb_uart_word_streamer.sv
// Randomized scoreboard bench for uart_word_streamer: a UART receiver and a
// read-address monitor pop expectations pushed by the transfer model.
module tb_uart_word_streamer;
    localparam int C        = 4;
    localparam int AW       = 14;
    localparam int WORD_CYC = 2 + 20 * C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_word_streamer_if #(.ADDR_W(AW)) bus ();

    uart_word_streamer #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (AW)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .bus     (bus)
    );

    logic [15:0] mem [0:(1<<AW)-1];
    logic [15:0] rd_q;
    always @(posedge clk) if (bus.rd_en) rd_q <= mem[bus.rd_address];
    assign bus.rd_data = rd_q;

    int errors = 0;
    int checks = 0;
    logic [7:0]    exp_bytes [$];
    logic [AW-1:0] exp_addrs [$];
    int rd_cnt = 0;
    int rx_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read-address monitor
    always @(negedge clk) begin
        if (!rst && bus.rd_en === 1'b1) begin
            rd_cnt++;
            if (exp_addrs.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra: got read at %0h, expected none", bus.rd_address);
            end else begin
                check("rd_address", 32'(bus.rd_address), 32'(exp_addrs.pop_front()));
            end
        end
    end

    // UART receiver sampling mid-bit
    bit         rx_act = 1'b0;
    int         rx_t;
    int         rx_i;
    logic [7:0] rx_b;
    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (bus.UART_TXD === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % C == C / 2) begin
                rx_i = rx_t / C;
                if (rx_i == 0) begin
                    if (bus.UART_TXD !== 1'b0) rx_act = 1'b0;
                end else if (rx_i < 9) begin
                    rx_b[rx_i-1] = bus.UART_TXD;
                end else begin
                    rx_act = 1'b0;
                    rx_cnt++;
                    check("stop_bit", 32'(bus.UART_TXD), 32'd1);
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_extra: got byte %0h, expected none", rx_b);
                    end else begin
                        check("rx_byte", 32'(rx_b), 32'(exp_bytes.pop_front()));
                    end
                end
            end
        end
    end

    // Issues one transfer; the model decides how many words go out.
    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] n,
                            input int abort_word, input bit abort_start,
                            input bit repulse);
        int nsent, k, done_k, abort_k, rd0, rx0, limit;
        bit line_low;
        logic [AW-1:0] a;
        nsent = int'(n);
        if (abort_start && n != 0) nsent = 1;
        else if (abort_word > 0 && abort_word < int'(n)) nsent = abort_word;
        for (int i = 0; i < nsent; i++) begin
            a = base + AW'(i);
            exp_addrs.push_back(a);
            exp_bytes.push_back(mem[a][7:0]);
            exp_bytes.push_back(mem[a][15:8]);
        end
        rd0 = rd_cnt;
        rx0 = rx_cnt;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.abort     = abort_start;
        bus.base_addr = base;
        bus.num_words = n;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base_addr = AW'($urandom);
        bus.num_words = AW'($urandom);
        k        = 1;
        done_k   = -1;
        abort_k  = -1;
        line_low = 1'b0;
        limit    = nsent * WORD_CYC + 20;
        check("busy_t1", 32'(bus.busy), 32'd1);
        check("rd_en_t1", 32'(bus.rd_en), 32'(n != 0));
        while (k < limit) begin
            if (bus.UART_TXD !== 1'b1) line_low = 1'b1;
            if (bus.done === 1'b1) begin
                done_k = k;
                break;
            end
            if (abort_word > 0 && abort_k < 0 && rd_cnt - rd0 == abort_word)
                abort_k = k + 10;
            bus.abort = (k == abort_k);
            bus.start = repulse && (k % 50 == 30);
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("done_cycle", 32'(done_k), 32'(nsent * WORD_CYC + 1));
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check("rd_pulses", 32'(rd_cnt - rd0), 32'(nsent));
        check("byte_count", 32'(rx_cnt - rx0), 32'(2 * nsent));
        if (n == 0) check("line_high", 32'(line_low), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(bus.UART_TXD), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
        check("idle_abort", 32'(bus.busy), 32'd0);

        mem[14'h0010] = 16'hA53C;
        run_xfer(14'h0010, 14'd1, 0, 1'b0, 1'b0);

        mem[14'h3FFE] = 16'h0001;
        mem[14'h3FFF] = 16'h0002;
        mem[14'h0000] = 16'h0003;
        run_xfer(14'h3FFE, 14'd3, 0, 1'b0, 1'b0);

        run_xfer(AW'($urandom), 14'd5, 2, 1'b0, 1'b0);
        run_xfer(AW'($urandom), 14'd0, 0, 1'b0, 1'b0);
        run_xfer(AW'($urandom), 14'd3, 0, 1'b1, 1'b0);
        run_xfer(AW'($urandom), 14'd2, 0, 1'b0, 1'b1);

        // Reset during a low data bit
        mem[14'h0005] = 16'h5A00;
        exp_addrs.push_back(14'h0005);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 14'h0005;
        bus.num_words = 14'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_rst_txd", 32'(bus.UART_TXD), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_txd", 32'(bus.UART_TXD), 32'd1);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_rd_en", 32'(bus.rd_en), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_xfer(AW'($urandom), 14'd1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int nw, aw;
            nw = $urandom_range(1, 3);
            aw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nw) : 0;
            run_xfer(AW'($urandom), AW'(nw), aw, 1'b0, t[0]);
        end

        check("addr_queue_empty", 32'(exp_addrs.size()), 32'd0);
        check("byte_queue_empty", 32'(exp_bytes.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
